// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline registers: control field widths,
// control bit positions, the EX/MEM entry layout and the skid-buffer states.
package riscv_pipe_pkg;
  localparam int WB_W = 2;
  localparam int M_W  = 3;

  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [WB_W-1:0]               wb;
    logic [M_W-1:0]                m;
    logic [DEF_DATA_WIDTH-1:0]     target;
    logic                          zero;
    logic [DEF_DATA_WIDTH-1:0]     alu;
    logic [DEF_DATA_WIDTH-1:0]     wdata;
    logic [DEF_REG_ADDR_WIDTH-1:0] wreg;
  } ex_mem_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ex_mem_state_t;
endpackage

// File: rtl/ex_mem_slot.sv
// One EX/MEM entry: payload register with load enable plus a valid bit.
// Flush clears only the valid bit; reset clears both valid and payload.
module ex_mem_slot
  import riscv_pipe_pkg::*;
#(
  parameter int W = $bits(ex_mem_entry_t)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (load && !flush) q <= d;
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (clear) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX->MEM pipeline register built as a two-entry skid buffer (main + skid),
// so a stalled data memory back-pressures EX without losing instructions.
module ex_mem
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic [WB_W-1:0]           ctlwb_in,
  input  logic [M_W-1:0]            ctlm_in,
  input  logic [DATA_WIDTH-1:0]     branch_target,
  input  logic                      zero_in,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] wreg_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WB_W-1:0]           wb_ctlout,
  output logic [M_W-1:0]            m_ctlout,
  output logic [DATA_WIDTH-1:0]     target_out,
  output logic                      zero_out,
  output logic [DATA_WIDTH-1:0]     aluresult_out,
  output logic [DATA_WIDTH-1:0]     wdata_out,
  output logic [REG_ADDR_WIDTH-1:0] wreg_out,
  output logic                      pcsrc
);

  typedef struct packed {
    logic [WB_W-1:0]           wb;
    logic [M_W-1:0]            m;
    logic [DATA_WIDTH-1:0]     target;
    logic                      zero;
    logic [DATA_WIDTH-1:0]     alu;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [REG_ADDR_WIDTH-1:0] wreg;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t        in_e, main_d, main_q, skid_q;
  logic          main_valid, skid_valid, ready_q;
  logic          accept, drain;
  logic          main_load, main_clear, skid_load, skid_clear;
  ex_mem_state_t state;

  assign in_e   = {ctlwb_in, ctlm_in, branch_target, zero_in, alu_result, store_data, wreg_in};
  // ready_q holds in_ready low through the reset cycle; afterwards only the skid occupancy matters
  assign in_ready = ready_q & ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_e;
    case (state)
      EMPTY: main_load = accept;
      ONE: begin
        main_load  = accept & drain;
        skid_load  = accept & ~drain;
        main_clear = ~accept & drain;
      end
      TWO: begin
        main_d     = skid_q;
        main_load  = drain;
        skid_clear = drain;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (flush) state <= EMPTY;
      else begin
        case (state)
          EMPTY: if (accept) state <= ONE;
          ONE: begin
            if (accept && !drain)      state <= TWO;
            else if (!accept && drain) state <= EMPTY;
          end
          TWO:     if (drain) state <= ONE;
          default: state <= EMPTY;
        endcase
      end
    end
  end

  ex_mem_slot #(.W(EW)) u_main (
    .clock(clock), .reset(reset), .flush(flush), .load(main_load), .clear(main_clear),
    .d(main_d), .q(main_q), .valid(main_valid)
  );

  ex_mem_slot #(.W(EW)) u_skid (
    .clock(clock), .reset(reset), .flush(flush), .load(skid_load), .clear(skid_clear),
    .d(in_e), .q(skid_q), .valid(skid_valid)
  );

  // Control is squashed to a NOP while the head is empty; data simply holds
  assign out_valid     = main_valid;
  assign wb_ctlout     = {main_valid & main_q.wb[REGWRITE], main_valid & main_q.wb[MEMTOREG]};
  assign m_ctlout      = {main_valid & main_q.m[BRANCH], main_valid & main_q.m[MEMREAD],
                          main_valid & main_q.m[MEMWRITE]};
  assign target_out    = main_q.target;
  assign zero_out      = main_q.zero;
  assign aluresult_out = main_q.alu;
  assign wdata_out     = main_q.wdata;
  assign wreg_out      = main_q.wreg;
  assign pcsrc         = main_valid & main_q.m[BRANCH] & main_q.zero;

endmodule
